// File: rtl/acc_dump_pkg.sv
// rtl/acc_dump_pkg.sv - shared state encoding, byte width and index-width helper for acc_dump
package acc_dump_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE,
    FINISH
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_dump_pacer.sv
// rtl/acc_dump_pacer.sv - per-byte UART handshake: strobe when idle, wait for busy (or timeout), wait for idle
module acc_dump_pacer
  import acc_dump_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              busy_tx_i,
  output logic              ack_o,
  output logic              transmit_o,
  output logic [BYTE_W-1:0] data_tx_o
);

  localparam int CNT_W = idx_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic [BYTE_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
    end
  end

  // A silent UART never raises busy; the timeout path still routes through
  // WAIT_IDLE so accepted bytes always advance from one place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = 1'b0;
    data_d  = data_q;
    ack_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = SEND;
      end
      SEND: begin
        if (!busy_tx_i) begin
          tx_d    = 1'b1;
          data_d  = byte_i;
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (busy_tx_i || (cnt_q == CNT_LAST)) state_d = WAIT_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      WAIT_IDLE: begin
        if (!busy_tx_i) begin
          ack_o   = 1'b1;
          state_d = req_i ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign transmit_o = tx_q;
  assign data_tx_o  = data_q;

endmodule

// File: rtl/acc_dump.sv
// rtl/acc_dump.sv - snapshots the accumulator on start and streams it LSB-first to the UART
// Optional trailing XOR checksum byte when ACC_DUMP_CHECKSUM_EN is defined.
module acc_dump
  import acc_dump_pkg::*;
#(
  parameter int NBYTES      = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     start,
  input  logic [NBYTES*BYTE_W-1:0] big,
  input  logic                     busy_tx,
  output logic                     transmit,
  output logic [BYTE_W-1:0]        data_tx,
  output logic                     active,
  output logic                     done
);

  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_e                          state_q, state_d;
  logic [NBYTES-1:0][BYTE_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            active_q, active_d;
  logic                            req, ack, last_byte;
  logic [BYTE_W-1:0]               cur_byte;

`ifdef ACC_DUMP_CHECKSUM_EN
  logic              csum_q, csum_d;
  logic [BYTE_W-1:0] xor_q, xor_d;

  assign last_byte = csum_q;
  assign cur_byte  = csum_q ? xor_q : snap_q[idx_q];
`else
  assign last_byte = (idx_q == IDX_LAST);
  assign cur_byte  = snap_q[idx_q];
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
`ifdef ACC_DUMP_CHECKSUM_EN
      csum_q   <= 1'b0;
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      active_q <= active_d;
`ifdef ACC_DUMP_CHECKSUM_EN
      csum_q   <= csum_d;
      xor_q    <= xor_d;
`endif
    end
  end

  // The top only tracks IDLE / SEND (dump in progress) / FINISH; the pacer owns the handshake states.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    active_d = active_q;
    req      = 1'b0;
`ifdef ACC_DUMP_CHECKSUM_EN
    csum_d   = csum_q;
    xor_d    = (transmit && !csum_q) ? (xor_q ^ data_tx) : xor_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d   = big;
          idx_d    = '0;
          active_d = 1'b1;
          req      = 1'b1;
          state_d  = SEND;
`ifdef ACC_DUMP_CHECKSUM_EN
          csum_d   = 1'b0;
          xor_d    = '0;
`endif
        end
      end
      SEND: begin
        req = !(ack && last_byte);
        if (ack) begin
          if (last_byte) state_d = FINISH;
`ifdef ACC_DUMP_CHECKSUM_EN
          else if (idx_q == IDX_LAST) csum_d = 1'b1;
`endif
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      FINISH: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  acc_dump_pacer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_pacer (
    .clk       (clk),
    .nRst      (nRst),
    .req_i     (req),
    .byte_i    (cur_byte),
    .busy_tx_i (busy_tx),
    .ack_o     (ack),
    .transmit_o(transmit),
    .data_tx_o (data_tx)
  );

  assign active = active_q;
  assign done   = (state_q == FINISH);

endmodule

// File: tb/tb_acc_dump.sv
// tb/tb_acc_dump.sv - table-driven and randomized checks of acc_dump against a byte-list reference model
module tb_acc_dump;

  localparam int NB = 16;
  localparam int AT = 4;

  logic            clk = 1'b0;
  logic            nRst = 1'b1;
  logic            start = 1'b0;
  logic [NB*8-1:0] big = '0;
  logic            busy_tx = 1'b0;
  logic            transmit;
  logic [7:0]      data_tx;
  logic            active;
  logic            done;

  acc_dump #(.NBYTES(NB), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .nRst(nRst), .start(start), .big(big), .busy_tx(busy_tx),
    .transmit(transmit), .data_tx(data_tx), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         uart_lat = 10;
  bit         force_busy = 1'b0;
  int         rem = 0;
  int         n_done = 0;
  logic [7:0] got_b[$];
  int         got_c[$];
  logic [7:0] exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART model plus capture: busy stays high for uart_lat cycles after each strobe.
  always @(negedge clk) begin
    if (transmit) begin
      got_b.push_back(data_tx);
      got_c.push_back(cyc);
    end
    if (done) n_done++;
    if (transmit) rem = uart_lat;
    else if (rem > 0) rem--;
    busy_tx = force_busy || (rem > 0);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int gap_for(input int lat);
    return (lat == 0) ? AT + 2 : lat + 2;
  endfunction

  task automatic build_exp(input logic [NB*8-1:0] w);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    exp_b.delete();
    for (int i = 0; i < NB; i++) begin
      b = 8'(w >> (8 * i));
      x = x ^ b;
      exp_b.push_back(b);
    end
`ifdef ACC_DUMP_CHECKSUM_EN
    exp_b.push_back(x);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [NB*8-1:0] w, input int lat, output int t0);
    uart_lat = lat;
    got_b.delete();
    got_c.delete();
    n_done = 0;
    build_exp(w);
    t0 = cyc;
    big = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("active_after_start", active, 1);
  endtask

  task automatic finish_dump(input int gap, input int first_exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    chk("done_seen", ok, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("byte_count", got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      chk($sformatf("byte%0d", i), got_b[i], exp_b[i]);
    if (got_c.size() > 0) chk("first_strobe_cycle", got_c[0], first_exp);
    for (int i = 1; i < got_c.size(); i++) chk("strobe_gap", got_c[i] - got_c[i-1], gap);
    chk("done_pulses", n_done, 1);
    chk("active_after_done", active, 0);
  endtask

  typedef struct {
    logic [NB*8-1:0] w;
    int              lat;
    int              gap;
    bit              disturb;
  } vec_t;

  localparam logic [NB*8-1:0] SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

  initial begin
    vec_t tbl[7];
    int   t0;
    int   d;
    int   n;

    tbl[0] = '{SEQ, 10, 12, 1'b0};
    tbl[1] = '{SEQ, 10, 12, 1'b1};
    tbl[2] = '{SEQ, 0, 6, 1'b0};
    tbl[3] = '{128'h01, 1, 3, 1'b0};
    tbl[4] = '{128'h01, 10, 12, 1'b0};
    for (int i = 5; i < 7; i++) begin
      tbl[i].w       = {$urandom(), $urandom(), $urandom(), $urandom()};
      tbl[i].lat     = $urandom_range(0, 6);
      tbl[i].gap     = gap_for(tbl[i].lat);
      tbl[i].disturb = 1'b0;
    end

    #2 nRst = 1'b0;
    repeat (3) tick();
    chk("rst_transmit", transmit, 0);
    chk("rst_data_tx", data_tx, 0);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    nRst = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 7; v++) begin
      start_dump(tbl[v].w, tbl[v].lat, t0);
      if (tbl[v].disturb) begin
        big = '1;
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      finish_dump(tbl[v].gap, t0 + 2);
    end

    // Busy held high across the start: no strobe until it drops.
    force_busy = 1'b1;
    tick();
    start_dump(SEQ, 10, t0);
    repeat (48) tick();
    chk("no_strobe_while_busy", got_b.size(), 0);
    chk("active_while_busy", active, 1);
    force_busy = 1'b0;
    d = cyc;
    finish_dump(12, d + 1);

    // Reset mid-dump, then a clean re-entry from byte 0.
    start_dump(SEQ, 10, t0);
    for (int i = 0; i < 600 && got_b.size() < 6; i++) tick();
    chk("reached_byte5", got_b.size() >= 6, 1);
    nRst = 1'b0;
    tick();
    n = got_b.size();
    chk("midrst_transmit", transmit, 0);
    chk("midrst_data_tx", data_tx, 0);
    chk("midrst_active", active, 0);
    chk("midrst_done", done, 0);
    repeat (3) tick();
    nRst = 1'b1;
    repeat (30) tick();
    chk("no_strobe_after_reset", got_b.size(), n);
    chk("idle_after_reset", active, 0);
    start_dump(SEQ, 10, t0);
    finish_dump(12, t0 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
